// File: rtl/ahb_lite_master.sv
// -----------------------------------------------------------------------------
// ahb_lite_master
//
// Turns one command (SINGLE, INCR4 or WRAP4, read or write) into an AHB-Lite
// transfer sequence and returns a one-cycle completion pulse. The pulse carries
// the read beats and a sticky ERROR flag.
//
// Ports
//   i_clk, i_reset          rising-edge clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready command handshake; accepted only in IDLE
//   i_cmd_write             1 = write, 0 = read
//   i_cmd_addr              start address; bits [1:0] are forced to 0
//   i_cmd_burst             00/11 SINGLE, 01 INCR4, 10 WRAP4
//   i_cmd_wdata             write beats, beat k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_rsp_valid             one-cycle completion pulse
//   o_rsp_err               an ERROR response was seen during the command
//   o_rsp_rdata             read beats, beat k in slot k (0 for writes/missed)
//   o_h* / i_h*             AHB-Lite master interface (word transfers only)
// -----------------------------------------------------------------------------
module ahb_lite_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   // command / response
   input  logic                      i_cmd_valid,
   output logic                      o_cmd_ready,
   input  logic                      i_cmd_write,
   input  logic [ADDR_WIDTH-1:0]     i_cmd_addr,
   input  logic [1:0]                i_cmd_burst,
   input  logic [4*DATA_WIDTH-1:0]   i_cmd_wdata,
   output logic                      o_rsp_valid,
   output logic                      o_rsp_err,
   output logic [4*DATA_WIDTH-1:0]   o_rsp_rdata,
   // AHB-Lite
   output logic [ADDR_WIDTH-1:0]     o_haddr,
   output logic [2:0]                o_hburst,
   output logic [3:0]                o_hprot,
   output logic [2:0]                o_hsize,
   output logic [1:0]                o_htrans,
   output logic [DATA_WIDTH-1:0]     o_hwdata,
   output logic                      o_hwrite,
   input  logic [DATA_WIDTH-1:0]     i_hrdata,
   input  logic                      i_hready,
   input  logic                      i_hresp
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_BURST,
      S_LAST,
      S_RESP
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;

   state_t                    state, state_nxt;

   // latched command
   logic [ADDR_WIDTH-1:0]     addr_q;       // address currently on the bus
   logic [2:0]                hburst_q;
   logic                      write_q;
   logic [4*DATA_WIDTH-1:0]   wdata_q;
   logic [4*DATA_WIDTH-1:0]   rdata_q;
   logic                      err_q;
   logic [1:0]                addr_beat_q;  // beat index of the address phase

   // pending data phase (trails the accepted address phase by one transfer)
   logic                      dp_valid_q;
   logic [1:0]                dp_beat_q;

   logic                      err_first;
   logic                      addr_accept;
   logic                      cmd_accept;
   logic [ADDR_WIDTH-1:0]     addr_next;
   logic [DATA_WIDTH-1:0]     hwdata;
   logic                      unused_addr_lsbs;

   // Bits [1:0] of the command address never reach the bus.
   assign unused_addr_lsbs = ^i_cmd_addr[1:0];

   assign cmd_accept = (state == S_IDLE) && i_cmd_valid;

   // First cycle of a two-cycle ERROR response: hready is still low, so the
   // address phase shown this cycle has not been taken and can be withdrawn.
   assign err_first = dp_valid_q && i_hresp && !i_hready;

   assign addr_accept = ((state == S_ADDR) || (state == S_BURST)) && i_hready;

   // WRAP4 stays inside the 16-byte block; INCR4 just steps by one word.
   always_comb begin
      addr_next = addr_q + ADDR_WIDTH'(4);
      if (hburst_q == HBURST_WRAP4) begin
         addr_next = {addr_q[ADDR_WIDTH-1:4], addr_q[3:2] + 2'd1, 2'b00};
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path through
   // the block can leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      o_htrans  = HTRANS_IDLE;

      unique case (state)
         S_IDLE: begin
            if (i_cmd_valid) state_nxt = S_ADDR;
         end

         S_ADDR: begin
            o_htrans = HTRANS_NONSEQ;
            if (i_hready) begin
               state_nxt = (hburst_q == HBURST_SINGLE) ? S_LAST : S_BURST;
            end
         end

         S_BURST: begin
            o_htrans = HTRANS_SEQ;
            if (err_first) begin
               state_nxt = S_LAST;
            end else if (i_hready && (addr_beat_q == 2'd3)) begin
               state_nxt = S_LAST;
            end
         end

         S_LAST: begin
            if (i_hready) state_nxt = S_RESP;
         end

         S_RESP: begin
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // An ERROR cancels the transfer being offered in the same cycle.
      if (err_first) o_htrans = HTRANS_IDLE;
   end

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge regardless of order.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state       <= S_IDLE;
         addr_q      <= '0;
         hburst_q    <= HBURST_SINGLE;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         addr_beat_q <= 2'd0;
         dp_valid_q  <= 1'b0;
         dp_beat_q   <= 2'd0;
      end else begin
         state <= state_nxt;

         if (cmd_accept) begin
            addr_q      <= {i_cmd_addr[ADDR_WIDTH-1:2], 2'b00};
            write_q     <= i_cmd_write;
            wdata_q     <= i_cmd_wdata;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            addr_beat_q <= 2'd0;
            unique case (i_cmd_burst)
               2'b01:   hburst_q <= HBURST_INCR4;
               2'b10:   hburst_q <= HBURST_WRAP4;
               default: hburst_q <= HBURST_SINGLE;
            endcase
         end

         // Address only moves once the next beat is actually going out, so the
         // bus shows the last issued address during LAST.
         if (addr_accept) begin
            addr_beat_q <= addr_beat_q + 2'd1;
            if (state_nxt == S_BURST) addr_q <= addr_next;
         end

         if (addr_accept) begin
            dp_valid_q <= 1'b1;
            dp_beat_q  <= addr_beat_q;
         end else if (i_hready) begin
            dp_valid_q <= 1'b0;
         end

         if (dp_valid_q && i_hready && !i_hresp && !write_q) begin
            for (int k = 0; k < 4; k++) begin
               if (dp_beat_q == 2'(k)) rdata_q[k*DATA_WIDTH +: DATA_WIDTH] <= i_hrdata;
            end
         end

         if (err_first) err_q <= 1'b1;
      end
   end

   // Write data follows its address phase by one transfer and is held, with
   // the data-phase register, for as long as the slave stretches it.
   always_comb begin
      hwdata = '0;
      if (dp_valid_q && write_q) begin
         for (int k = 0; k < 4; k++) begin
            if (dp_beat_q == 2'(k)) hwdata = wdata_q[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign o_cmd_ready = (state == S_IDLE);
   assign o_rsp_valid = (state == S_RESP);
   assign o_rsp_err   = err_q;
   assign o_rsp_rdata = rdata_q;

   assign o_haddr  = addr_q;
   assign o_hburst = hburst_q;
   assign o_hwrite = write_q;
   assign o_hwdata = hwdata;
   assign o_hsize  = 3'b010;
   assign o_hprot  = 4'b0011;

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, AHB data width.
REQ-002 The block SHALL use one clock and one asynchronous active-high reset:
- i_clk  in  1  clock; all logic is rising-edge.
- i_reset  in  1  asynchronous, active-high reset.
REQ-003 Command ports SHALL be:
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  block can accept a command.
- i_cmd_write  in  1  1=write, 0=read.
- i_cmd_addr  in  ADDR_WIDTH  start address; bits [1:0] are ignored and forced to 0.
- i_cmd_burst  in  2  burst type: 00=SINGLE, 01=INCR4, 10=WRAP4, 11=SINGLE.
- i_cmd_wdata  in  4*DATA_WIDTH  write data; beat k is bits [k*DW+:DW].
REQ-004 Response ports SHALL be:
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_err  out  1  an ERROR response was seen during the command.
- o_rsp_rdata  out  4*DATA_WIDTH  read beats, beat k in slot k.
REQ-005 AHB-Lite master ports SHALL be:
- o_haddr  out  ADDR_WIDTH
- o_hburst  out  3
- o_hprot  out  4
- o_hsize  out  3
- o_htrans  out  2
- o_hwdata  out  DATA_WIDTH
- o_hwrite  out  1
- i_hrdata  in  DATA_WIDTH
- i_hready  in  1
- i_hresp  in  1

Function
REQ-006 Fixed outputs SHALL be: o_hsize=3'b010 and o_hprot=4'b0011.
REQ-007 o_hburst SHALL be 000 for SINGLE, 011 for INCR4 and 010 for WRAP4; it is held for the whole burst.
REQ-008 The FSM SHALL have the states IDLE, ADDR, BURST, LAST, RESP.
REQ-009 IDLE SHALL behave as follows:
- o_cmd_ready=1 and o_htrans=00.
- When i_cmd_valid=1, the block latches the command and moves to ADDR.
REQ-010 ADDR SHALL drive o_htrans=NONSEQ(10) with o_haddr set to the start address and o_hwrite set to the command type. On i_hready=1 it goes to LAST if the beat count is 1, otherwise to BURST.
REQ-011 BURST SHALL drive o_htrans=SEQ(11) with the next beat address. It advances on each i_hready=1 and goes to LAST after the address of beat 3 is accepted.
REQ-012 LAST SHALL drive o_htrans=IDLE(00) and wait for the final data phase to complete (i_hready=1), then go to RESP.
REQ-013 RESP SHALL assert o_rsp_valid=1 for one cycle and then return to IDLE. o_cmd_ready=0 in every state except IDLE.
REQ-014 Address, control and o_htrans SHALL be held stable while i_hready=0. The master SHALL never issue BUSY.
REQ-015 INCR4 SHALL advance the address by 4 per beat; wrap-around at 2^ADDR_WIDTH is unchecked.
REQ-016 WRAP4 SHALL compute the next address as {addr[AW-1:4], addr[3:2]+2'd1, 2'b00}, giving a 16-byte wrap.
REQ-017 Writes SHALL drive o_hwdata with beat k in the cycle after beat k's address is accepted, held until i_hready=1.
REQ-018 Reads SHALL capture i_hrdata into slot k on the cycle where beat k's data phase completes with i_hready=1 and i_hresp=0.
REQ-019 ERROR handling: when i_hresp=1 and i_hready=0 (first ERROR cycle), the master SHALL drive o_htrans=IDLE in the same cycle, cancel all remaining beats, set a sticky error flag and go to LAST.
REQ-020 After an ERROR, LAST SHALL complete on the second ERROR cycle (i_hready=1). Slots that were not captured read 0.
REQ-021 o_rsp_err SHALL equal the sticky error flag and be valid with o_rsp_valid. The flag clears on command accept.
REQ-022 o_rsp_rdata SHALL be cleared to 0 on command accept. For writes it stays 0.
REQ-023 Latency with zero wait states SHALL be: accept-to-o_rsp_valid = beats+2 cycles (SINGLE=3, 4-beat=6).

Reset
REQ-024 While i_reset=1, outputs SHALL be:
- o_htrans=00, o_haddr=0, o_hwdata=0, o_hwrite=0, o_hburst=000.
- o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0.
- o_cmd_ready=1; FSM state = IDLE.
REQ-025 Reset asserted mid-burst SHALL abort immediately: the bus goes IDLE and no o_rsp_valid is produced. The first command after release starts with NONSEQ.

Verification
REQ-026 WRAP4 write at 0x44A0_0004, zero waits: o_haddr=04,08,0C,00 (upper 0x44A0_00) with htrans NONSEQ,SEQ,SEQ,SEQ; hwdata beats 0..3 one cycle later; o_rsp_valid at cycle 6 with err=0.
REQ-027 WRAP4 read at the same address with a slave returning 0xA,0xB,0xC,0xD: o_rsp_rdata slots hold 0xA..0xD in order; err=0.
REQ-028 INCR4 write at 0x1000 with 2 wait states on beat 1: addresses 1000,1004,1008,100C; address and data held stable during the waits; o_rsp_valid at cycle 8.
REQ-029 SINGLE read at 0x2000 returning 0x1234_5678: hburst=000; slot0=0x1234_5678, other slots=0; o_rsp_valid at cycle 3.
REQ-030 INCR4 read with ERROR on beat 1's data phase: htrans=IDLE in the first ERROR cycle; no further beats issued; slot0 holds data, slots 1..3=0; err=1.
REQ-031 i_reset pulse during beat 2 of an INCR4: htrans=00 immediately; no o_rsp_valid; the next SINGLE write completes normally with err=0.
